pipe_ctrl: RTL

Pipeline stall/flush controller for the 5-stage MIPS core. It arbitrates stall requests from the ID stage (operand/load-use hazard) and the EX stage (multi-cycle operation busy) and produces the per-stage stall vector. It sequences exception/ERET flushes by issuing a one-cycle flush with the redirect PC. It also tracks stall duration and raises a sticky watchdog flag on a runaway stall.

---
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl.sv | 86 ++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Bundle of request/response signals between the pipeline stages and the
// stall/flush controller. The master side is the core (requesters), the
// slave side is pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             stallreq_id;
   logic             stallreq_ex;
   logic             flush_req;
   logic [31:0]      flush_pc_i;
   logic [5:0]       stall_o;
   logic             flush_o;
   logic [31:0]      new_pc_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic             timeout_o;

   modport master (
      output stallreq_id, stallreq_ex, flush_req, flush_pc_i,
      input  stall_o, flush_o, new_pc_o, stall_cnt_o, timeout_o
   );

   modport slave (
      input  stallreq_id, stallreq_ex, flush_req, flush_pc_i,
      output stall_o, flush_o, new_pc_o, stall_cnt_o, timeout_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core.
// Stalls are combinational (same-cycle freeze); flushes are registered and
// last one cycle per sampled flush request. A saturating counter measures
// consecutive stalled cycles and trips a sticky watchdog flag.
module pipe_ctrl #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,      // active-low, asynchronous
   pipe_ctrl_if.slave  bus
);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [31:0]      r_new_pc;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_timeout;
   logic [5:0]       w_stall;
   logic             w_stalled;

   // Stall vector: a flush (pending or in progress) overrides any stall;
   // EX stall freezes through EX, ID stall freezes through ID.
   always_comb begin
      w_stall = 6'b000000;
      if (!rst || (r_state == FLUSH) || bus.flush_req) begin
         w_stall = 6'b000000;
      end else if (bus.stallreq_ex) begin
         w_stall = 6'b001111;
      end else if (bus.stallreq_id) begin
         w_stall = 6'b000111;
      end
   end

   assign w_stalled = (w_stall != 6'b000000);

   // Next state: every sampled flush request buys exactly one FLUSH cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN:     w_state_next = bus.flush_req ? FLUSH : RUN;
         FLUSH:   w_state_next = bus.flush_req ? FLUSH : RUN;
         default: w_state_next = RUN;
      endcase
   end

   // State register; async reset drops an in-progress flush immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= RUN;
      else      r_state <= w_state_next;
   end

   // Redirect PC capture on every sampled flush request, held otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               r_new_pc <= 32'h0000_0000;
      else if (bus.flush_req) r_new_pc <= bus.flush_pc_i;
   end

   // Consecutive-stall counter, cleared by any non-stalled cycle, saturating.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      r_stall_cnt <= '0;
      else if (!w_stalled)           r_stall_cnt <= '0;
      else if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   // Sticky watchdog: trips on the TIMEOUT-th consecutive stalled cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                      r_timeout <= 1'b0;
      else if (w_stalled && (r_stall_cnt == TMO_M1)) r_timeout <= 1'b1;
   end

   assign bus.stall_o     = w_stall;
   assign bus.flush_o     = (r_state == FLUSH);
   assign bus.new_pc_o    = r_new_pc;
   assign bus.stall_cnt_o = r_stall_cnt;
   assign bus.timeout_o   = r_timeout;

endmodule
